// File: rtl/reg_file_pkg.sv
// Shared sizing defaults and FSM encoding for the 8x8 register file with
// stall-tolerant write buffering.
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_8x8_chk.sv
// Protocol checks on the write-buffer state; has no effect on behaviour.
module reg_file_8x8_chk (
  input logic clk,
  input logic reset,
  input logic write,
  input logic busywait,
  input logic write_pending,
  input logic state_pending
);

  a_flag_matches_state: assert property (@(posedge clk)
    write_pending == state_pending);

  a_reset_clears_pending: assert property (@(posedge clk)
    !reset |=> !write_pending);

  a_stalled_write_held: assert property (@(posedge clk)
    (reset && write && busywait) |=> write_pending);

  a_release_drains: assert property (@(posedge clk)
    (reset && write_pending && !busywait) |=> !write_pending);

endmodule : reg_file_8x8_chk

// File: rtl/reg_file_read_port.sv
// One combinational read port: array mux with a bypass from the held
// (stalled) write so readers see the value that is about to commit.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0] regs,
  input  logic [ADDR_WIDTH-1:0]                      addr,
  input  logic                                       bypass_valid,
  input  logic [ADDR_WIDTH-1:0]                      bypass_addr,
  input  logic [DATA_WIDTH-1:0]                      bypass_data,
  output logic [DATA_WIDTH-1:0]                      data
);

  logic bypass_hit_s;

  // Select pending data when it targets this port's address, else the array.
  always_comb begin
    bypass_hit_s = bypass_valid && (addr == bypass_addr);
    if (bypass_hit_s) begin
      data = bypass_data;
    end else begin
      data = regs[addr];
    end
  end

endmodule : reg_file_read_port

// File: rtl/reg_file_8x8.sv
// Register file with two combinational read ports and a one-deep write buffer
// that holds a write issued during a processor stall until the stall clears.
module reg_file_8x8
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] IN,
  input  logic [ADDR_WIDTH-1:0] INADDRESS,
  input  logic                  WRITE,
  input  logic                  BUSYWAIT,
  input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0] OUT1,
  output logic [DATA_WIDTH-1:0] OUT2,
  output logic                  WRITE_PENDING
);

  localparam int REG_COUNT = 2 ** ADDR_WIDTH;

  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_r;
  state_t                               state_r;
  state_t                               state_nxt_s;
  logic [DATA_WIDTH-1:0]                pend_data_r;
  logic [ADDR_WIDTH-1:0]                pend_addr_r;
  logic                                 write_pending_r;

  logic                  commit_en_s;
  logic [ADDR_WIDTH-1:0] commit_addr_s;
  logic [DATA_WIDTH-1:0] commit_data_s;
  logic                  capture_en_s;

  // Decide this cycle's single array write, buffer capture and next state.
  always_comb begin
    commit_en_s   = 1'b0;
    commit_addr_s = INADDRESS;
    commit_data_s = IN;
    capture_en_s  = 1'b0;
    state_nxt_s   = state_r;
    case (state_r)
      IDLE: begin
        if (WRITE && !BUSYWAIT) begin
          commit_en_s = 1'b1;
          state_nxt_s = IDLE;
        end else if (WRITE && BUSYWAIT) begin
          capture_en_s = 1'b1;
          state_nxt_s  = PENDING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PENDING: begin
        if (BUSYWAIT) begin
          // Latest stalled write replaces the buffered one.
          capture_en_s = WRITE;
          state_nxt_s  = PENDING;
        end else if (WRITE) begin
          // A fresh write supersedes the buffered one, which is dropped.
          commit_en_s = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          commit_en_s   = 1'b1;
          commit_addr_s = pend_addr_r;
          commit_data_s = pend_data_r;
          state_nxt_s   = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Array, pending buffer and FSM state; reset overrides any commit.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      regs_r          <= '0;
      pend_data_r     <= {DATA_WIDTH{1'b0}};
      pend_addr_r     <= {ADDR_WIDTH{1'b0}};
      state_r         <= IDLE;
      write_pending_r <= 1'b0;
    end else begin
      if (commit_en_s) begin
        regs_r[commit_addr_s] <= commit_data_s;
      end else begin
        regs_r <= regs_r;
      end
      if (capture_en_s) begin
        pend_data_r <= IN;
        pend_addr_r <= INADDRESS;
      end else if (state_nxt_s == IDLE) begin
        pend_data_r <= {DATA_WIDTH{1'b0}};
        pend_addr_r <= {ADDR_WIDTH{1'b0}};
      end else begin
        pend_data_r <= pend_data_r;
        pend_addr_r <= pend_addr_r;
      end
      state_r         <= state_nxt_s;
      write_pending_r <= (state_nxt_s == PENDING);
    end
  end

  assign WRITE_PENDING = write_pending_r;

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port1 (
    .regs         (regs_r),
    .addr         (OUT1ADDRESS),
    .bypass_valid (write_pending_r),
    .bypass_addr  (pend_addr_r),
    .bypass_data  (pend_data_r),
    .data         (OUT1)
  );

  reg_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port2 (
    .regs         (regs_r),
    .addr         (OUT2ADDRESS),
    .bypass_valid (write_pending_r),
    .bypass_addr  (pend_addr_r),
    .bypass_data  (pend_data_r),
    .data         (OUT2)
  );

  reg_file_8x8_chk u_chk (
    .clk           (CLK),
    .reset         (RESET),
    .write         (WRITE),
    .busywait      (BUSYWAIT),
    .write_pending (WRITE_PENDING),
    .state_pending (state_r == PENDING)
  );

endmodule : reg_file_8x8

// File: doc/reg_file_8x8.md
REG_FILE_8X8 -- requirements
Module: reg_file_8x8

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set register and data-port width.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set address width; register count = 2**ADDR_WIDTH.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 RESET  input  1  SHALL be a synchronous, active-low reset.
REQ-005 IN  input  DATA_WIDTH  SHALL carry write data (ALU RESULT).
REQ-006 INADDRESS  input  ADDR_WIDTH  SHALL be the write register index.
REQ-007 WRITE  input  1  SHALL request a write of IN to INADDRESS.
REQ-008 BUSYWAIT  input  1  SHALL signal a processor stall; high = commit not allowed.
REQ-009 OUT1ADDRESS, OUT2ADDRESS  input  ADDR_WIDTH each  SHALL be the read indices.
REQ-010 OUT1, OUT2  output  DATA_WIDTH each  SHALL be the read data (ALU DATA1/DATA2 sources).
REQ-011 WRITE_PENDING  output  1  SHALL be high while a stalled write is held.

Function
REQ-012 Reads SHALL be combinational, zero-cycle latency, and independent per port.
REQ-013 Same-cycle read of INADDRESS SHALL return the old value; new value visible after the edge.
REQ-014 FSM states SHALL be IDLE and PENDING; reset state IDLE.
REQ-015 IDLE, WRITE=1, BUSYWAIT=0: IN SHALL be written to INADDRESS at the edge; stay IDLE.
REQ-016 IDLE, WRITE=1, BUSYWAIT=1: IN/INADDRESS SHALL be captured into the pending buffer; go PENDING; no array write.
REQ-017 PENDING, BUSYWAIT=1: pending buffer SHALL be re-captured from IN/INADDRESS if WRITE=1 (latest wins), else held; stay PENDING.
REQ-018 PENDING, BUSYWAIT=0, WRITE=1: current IN SHALL be written to current INADDRESS; pending buffer discarded; go IDLE.
REQ-019 PENDING, BUSYWAIT=0, WRITE=0: pending buffer SHALL be written to its address; go IDLE.
REQ-020 At most one array write SHALL occur per cycle.
REQ-021 WRITE=0 in IDLE SHALL leave all state unchanged regardless of BUSYWAIT.
REQ-022 In PENDING, a read port whose address equals the pending address SHALL return pending data (bypass); other addresses return array contents.
REQ-023 WRITE_PENDING SHALL be 1 exactly when the state is PENDING.
REQ-024 All registers SHALL be writable, including index 0 (no hardwired zero).

Reset
REQ-025 RESET=0 at a rising edge SHALL clear all registers to 0, clear the pending buffer, and force IDLE.
REQ-026 Reset SHALL take priority over any write or pending commit in the same cycle.
REQ-027 After reset OUT1/OUT2 SHALL read 0 for any address and WRITE_PENDING SHALL be 0.
REQ-028 RESET SHALL have no asynchronous effect between edges.

Structure
REQ-029 Package reg_file_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults, NUM_REGS, and the FSM state encoding.
REQ-030 Sub-module reg_file_read_port (address mux + pending bypass) SHALL be instantiated once per read port.
REQ-031 Write control, FSM, and pending buffer SHALL reside in reg_file_8x8.

Verification
REQ-032 Reset, then read all 8 addresses on both ports -> all 0x00, WRITE_PENDING=0.
REQ-033 WRITE=1, IN=0x5A, INADDRESS=3, BUSYWAIT=0; OUT1ADDRESS=3 -> OUT1=0x00 that cycle, 0x5A next cycle.
REQ-034 WRITE=1, IN=0x11, INADDRESS=2, BUSYWAIT=1 for 3 cycles, then WRITE=0, BUSYWAIT=0 -> WRITE_PENDING=1 for 3 cycles, OUT2(addr 2)=0x11 via bypass, reg2=0x11 after release.
REQ-035 Stall with pending (addr 4, 0x22), then release with WRITE=1, IN=0x33, INADDRESS=5 -> reg5=0x33, reg4 unchanged (0x00), WRITE_PENDING=0.
REQ-036 Pending write (addr 1, 0x7F) with RESET=0 asserted in the release cycle -> reg1=0x00, IDLE, WRITE_PENDING=0.
REQ-037 Fill regs 0..7 with 0xF0+i, read pairs (0,7),(3,4) simultaneously -> OUT1/OUT2 = 0xF0/0xF7, 0xF3/0xF4.
